// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Optional zero-divisor fast path enabled by defining DIV_ZERO_DETECT_EN.
module div_unit #(
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_a_q, neg_a_d;
  logic           neg_b_q, neg_b_d;
  logic [2*W-1:0] result_d;
  logic           ready_d;

  logic [W:0]     shifted_c;
  logic           ge_c;
  logic [W-1:0]   diff_c;
  logic           zero_fast_c;
  logic           op_neg_a_c, op_neg_b_c;
  logic [W-1:0]   quo_fix_c, rem_fix_c;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_fast_c = (opdata2_i == '0);
`else
  assign zero_fast_c = 1'b0;
`endif

  assign op_neg_a_c = signed_div_i & opdata1_i[W-1];
  assign op_neg_b_c = signed_div_i & opdata2_i[W-1];

  // One restoring step: trial subtract of the divisor from the shifted partial remainder
  assign shifted_c = {rem_q, dvd_q[W-1]};
  assign ge_c      = (shifted_c >= {1'b0, dvs_q});
  assign diff_c    = W'(shifted_c - {1'b0, dvs_q});

  // Sign fixup: quotient negative when signs differ, remainder follows the dividend
  assign quo_fix_c = (neg_a_q ^ neg_b_q) ? (~dvd_q + W'(1)) : dvd_q;
  assign rem_fix_c = neg_a_q ? (~rem_q + W'(1)) : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FREE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_o;
    ready_d  = ready_o;

    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (zero_fast_c) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            dvd_d   = op_neg_a_c ? (~opdata1_i + W'(1)) : opdata1_i;
            dvs_d   = op_neg_b_c ? (~opdata2_i + W'(1)) : opdata2_i;
            neg_a_d = op_neg_a_c;
            neg_b_d = op_neg_b_c;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
`ifdef DIV_ZERO_DETECT_EN
      BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = END;
      end
`endif
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CW'(DIV_ITER)) begin
          result_d = {rem_fix_c, quo_fix_c};
          ready_d  = 1'b1;
          state_d  = END;
        end else begin
          rem_d = ge_c ? diff_c : shifted_c[W-1:0];
          dvd_d = {dvd_q[W-2:0], ge_c};
          cnt_d = cnt_q + CW'(1);
        end
      end
      END: begin
        // Result held until EX drops its request; no wait for a new one
        if (!start_i || annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d  = FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands against an arithmetic model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_assert = 0;
  int n_fail   = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder takes dividend sign
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
      return 64'd0;
`else
      if (s && a[31]) return {a, 32'd1};
      return {a, 32'hFFFF_FFFF};
`endif
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) return 2;
`endif
    return 34;
  endfunction

  // Count edges until ready (bounded); scrambles operands after the sampling edge.
  task automatic wait_ready(input int lat, input logic [63:0] exp, input string tag, input bit drop);
    int edges = 0;
    bit seen  = 1'b0;
    while (edges < 40 && !seen) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (ready_o) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(edges), 64'(lat));
    check({tag, "_result"}, result_o, exp);
    if (drop) begin
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, "_hold_result"}, result_o, exp);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
      check({tag, "_drop_result"}, result_o, 64'd0);
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lat, input string tag);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    wait_ready(lat, exp, tag, 1'b1);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    int          k;

    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", 64'(ready_o), 64'd0);

    run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, "divu_100_7");
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, "div_m7_2");
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34, "div_ovf");
    run(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 34, "divu_max_1");
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34, "div_7_m2");
`ifdef DIV_ZERO_DETECT_EN
    run(1'b0, 32'd5, 32'd0, 64'd0, 2, "div_by_zero");
`else
    run(1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 34, "div_by_zero");
`endif

    // Annul on the 10th edge of an ON sequence, then an immediate new request
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      check("annul_pre_ready", 64'(ready_o), 64'd0);
    end
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    wait_ready(34, 64'h00000000_00000003, "after_annul", 1'b1);

    // Reset asserted between edges mid-ON
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_on_ready", 64'(ready_o), 64'd0);
    check("rst_on_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, "after_rst_on");

    // Reset while a nonzero result is being held in END
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    wait_ready(34, 64'h00000002_0000000E, "pre_rst_end", 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, "after_rst_end");

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      k = $urandom_range(0, 4);
      case (k)
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'(0) - 32'($urandom_range(1, 15));
        3:       b = 32'd0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i == 0) begin
        s = 1'b1;
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run(s, a, b, ref_div(s, a, b), ref_lat(b), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
